// File: rtl/rv_id_stage.sv
// Instruction-decode stage: 2-entry skid buffer that decodes fetched
// instruction/PC pairs and presents registered fields to execute.
module rv_id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [6:0]      opcode_o,
  output logic [3:0]      instr_part_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; the sender holds its payload stable while valid && !ready.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [3:0]      part;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, dec;
  logic   ready_q;
  logic   accept, fire;
  logic   load_main_dec, load_main_skid, load_skid;

  assign accept = if_valid_i & ready_q;
  assign fire   = id_valid_o & id_ready_i;

  always_comb begin
    dec         = '0;
    dec.opcode  = if_instr_i[6:0];
    dec.part    = {if_instr_i[30], if_instr_i[14:12]};
    dec.rd      = if_instr_i[11:7];
    dec.rs1     = if_instr_i[19:15];
    dec.rs2     = if_instr_i[24:20];
    dec.pc      = if_pc_i;
    case (if_instr_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        dec.imm = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      7'b0100011:
        dec.imm = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      7'b1100011:
        dec.imm = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                   if_instr_i[30:25], if_instr_i[11:8], 1'b0};
      7'b1101111:
        dec.imm = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                   if_instr_i[20], if_instr_i[30:21], 1'b0};
      7'b0110111, 7'b0010111:
        dec.imm = {if_instr_i[31:12], 12'b0};
      7'b0110011:
        dec.imm = '0;
      default:
        dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d       = ST_HALF;
        load_main_dec = 1'b1;
      end
      ST_HALF: begin
        if (accept && !fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (accept && fire) begin
          load_main_dec = 1'b1;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (fire) begin
        state_d        = ST_HALF;
        load_main_skid = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops both entries and anything accepted this cycle.
    if (flush_i) begin
      state_d        = ST_EMPTY;
      load_main_dec  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      if (load_main_dec)       main_q <= dec;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec;
    end
  end

  assign if_ready_o   = ready_q;
  assign id_valid_o   = (state_q != ST_EMPTY);
  assign opcode_o     = main_q.opcode;
  assign instr_part_o = main_q.part;
  assign rd_o         = main_q.rd;
  assign rs1_o        = main_q.rs1;
  assign rs2_o        = main_q.rs2;
  assign imm_o        = main_q.imm;
  assign pc_o         = main_q.pc;
  assign illegal_o    = main_q.illegal;

endmodule

// File: doc/rv_id_stage.md
Name: rv_id_stage

Overview:
- Instruction-decode pipeline stage between instruction fetch and the execute stage.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Presents registered decoded fields downstream: opcode, ALU-control selector bits {funct7[5], funct3}, register indices, sign-extended immediate, PC and an illegal flag.
- The opcode and selector bits are driven directly into the ALU control unit.

Parameters:
XLEN, 32, data/PC/immediate width (only 32 supported)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush: discard all buffered entries
if_valid_i  in  1  fetch offers an instruction
if_ready_o  out  1  stage can accept (registered)
if_instr_i  in  32  instruction word
if_pc_i  in  XLEN  PC of instruction
id_valid_o  out  1  decoded entry valid downstream
id_ready_i  in  1  execute consumes entry
opcode_o  out  7  instr[6:0]
instr_part_o  out  4  {instr[30], instr[14:12]}
rd_o  out  5  instr[11:7]
rs1_o  out  5  instr[19:15]
rs2_o  out  5  instr[24:20]
imm_o  out  XLEN  decoded immediate
pc_o  out  XLEN  PC of presented entry
illegal_o  out  1  opcode not supported

Behaviour:
- Reset (async, rst_n_i=0): state=EMPTY; if_ready_o=0; id_valid_o=0; all data outputs 0; skid entry cleared.
- if_ready_o goes 1 on the first rising edge after reset release.
- Handshake terms:
  - accept = if_valid_i & if_ready_o
  - fire = id_valid_o & id_ready_i
  - Producers hold data stable while valid && !ready; so does this block on its output side.
- Decode is combinational on the incoming word; the result is registered into the main or skid entry. Latency: input accepted at edge N appears on outputs after edge N (1 cycle) when the stage was empty.
- Immediate rules (by opcode):
  - I (0010011, 0000011, 1100111): sext(instr[31:20])
  - S (0100011): sext({instr[31:25], instr[11:7]})
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - R (0110011): 0
- illegal_o=1 for any opcode outside the set above; imm_o=0 in that case. Fields are still passed through and the entry still flows.
- instr_part_o is passed raw for every format; the consumer ignores it where it is meaningless.
- State machine (EMPTY / HALF / FULL). Outputs always show the main entry. if_ready_o next = (next_state != FULL).
  - EMPTY: accept -> HALF, main<=decoded.
  - HALF, accept & !fire -> FULL, skid<=decoded.
  - HALF, accept & fire -> HALF, main<=decoded.
  - HALF, !accept & fire -> EMPTY.
  - HALF, neither -> HALF, hold.
  - FULL: if_ready_o=0, so no accept. fire -> HALF, main<=skid; else hold.
- id_valid_o = (state != EMPTY).
- Simultaneous accept and fire in HALF is lossless; throughput is 1/cycle.
- flush_i has highest priority:
  - Next state=EMPTY; id_valid_o=0 next cycle; if_ready_o=1 next cycle.
  - Any word accepted in the flush cycle is discarded.
  - A fire in the flush cycle still counts downstream; the entry is then gone.
- Data outputs hold their last value when id_valid_o=0. They are not required to clear, except on reset.

Test Plan:
- Reset mid-stream: assert rst_n_i=0 with FULL state -> id_valid_o=0, if_ready_o=0, imm_o=0 immediately; after release, if_ready_o=1 on next edge.
- Accept 0x40B50533 (sub x10,x10,x11), PC 0x100, id_ready_i=1 -> next cycle: opcode_o=0110011, instr_part_o=1000, rd/rs1=10, rs2=11, imm_o=0, pc_o=0x100, illegal_o=0.
- Decode immediates:
  - 0xFFF00093 (addi x1,x0,-1) -> imm_o=0xFFFFFFFF, instr_part_o=1000.
  - 0xFE000CE3 (beq x0,x0,-8) -> imm_o=0xFFFFFFF8, instr_part_o[2:0]=000.
- Backpressure: id_ready_i=0, offer 3 back-to-back words -> first two accepted, if_ready_o=0 after second, third held. Raise id_ready_i -> outputs in order, no loss or duplication, if_ready_o returns 1 one cycle after first fire.
- Flush while FULL with if_valid_i=1 -> next cycle id_valid_o=0, both entries dropped, the in-flight word is not presented, if_ready_o=1.
- Instruction 0x00000000 -> illegal_o=1, imm_o=0, id_valid_o=1. Continuous random valid/ready for 10k cycles against a reference-model scoreboard -> zero mismatches.
